// File: rtl/cpld_ram_dma_pkg.sv
// Shared constants for the CPLD expansion-RAM DMA engine:
// register offsets, control bit positions, FSM states, counter width.
package cpld_ram_dma_pkg;

  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_PAGES  = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_FILL   = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_FILL  = 1;
  localparam int CTRL_ABORT = 2;

  localparam int CNT_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_e;

  // Page count 0 means 256 pages of 256 bytes.
  function automatic logic [CNT_W-1:0] page_bytes(input logic [7:0] pages);
    return (pages == 8'd0) ? 17'h10000 : {1'b0, pages, 8'h00};
  endfunction

endpackage

// File: rtl/cpld_ram_dma_if.sv
// SRAM bus between the DMA/CPU mux (master) and the SRAM pair (slave).
// ramadr[ADR_W-2:0], two chip selects, oe/we, engine data out + enable, data in.
interface cpld_ram_dma_if #(
  parameter int ADR_W = 20
);
  logic [ADR_W-2:0] ramadr;
  logic             ramcs0_b;
  logic             ramcs1_b;
  logic             ramoe_b;
  logic             ramwe_b;
  logic [7:0]       ram_dout;
  logic             ram_doe;
  logic [7:0]       ram_din;

  modport master (
    output ramadr, ramcs0_b, ramcs1_b, ramoe_b, ramwe_b,
    output ram_dout, ram_doe,
    input  ram_din
  );

  modport slave (
    input  ramadr, ramcs0_b, ramcs1_b, ramoe_b, ramwe_b,
    input  ram_dout, ram_doe,
    output ram_din
  );
endinterface

// File: rtl/cpld_dma_addrgen.sv
// Working src/dst byte addresses and remaining-byte counter.
// load_i seeds all three; step_i advances after a committed write.
module cpld_dma_addrgen
  import cpld_ram_dma_pkg::*;
#(
  parameter int ADR_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [ADR_W-1:0] src_i,
  input  logic [ADR_W-1:0] dst_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [ADR_W-1:0] src_o,
  output logic [ADR_W-1:0] dst_o,
  output logic             last_o
);

  logic [ADR_W-1:0] src_q, src_d;
  logic [ADR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      cnt_d = cnt_i;
    end else if (step_i) begin
      // Natural wrap at 2^ADR_W crosses chips transparently.
      src_d = src_q + 1'b1;
      dst_d = dst_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cpld_ram_dma.sv
// Page copy/fill DMA for the expansion SRAM with CPU priority.
// Ports: clk/reset, io_* register writes, cpu_* bus, ram (SRAM), busy/done/aborted.
module cpld_ram_dma
  import cpld_ram_dma_pkg::*;
#(
  parameter int ADR_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_wr,
  input  logic [2:0]       io_adr,
  input  logic [7:0]       io_data,
  input  logic             cpu_req,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic             cpu_rd_b,
  input  logic             cpu_wr_b,
  cpld_ram_dma_if.master   ram,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  state_e     state_q;
  logic [11:0] src_hi_q;
  logic [11:0] dst_hi_q;
  logic [7:0]  pages_q;
  logic [7:0]  fill_q;
  logic [7:0]  latch_q;
  logic        fill_mode_q;
  logic        done_q;
  logic        aborted_q;

  logic             idle;
  logic             ctrl_wr;
  logic             start;
  logic             abort;
  logic             commit;
  logic             step;
  logic             last;
  logic [ADR_W-1:0] src_a;
  logic [ADR_W-1:0] dst_a;
  logic [ADR_W-1:0] src_base;
  logic [ADR_W-1:0] dst_base;

  assign idle     = (state_q == ST_IDLE);
  assign ctrl_wr  = io_wr && (io_adr == REG_CTRL);
  assign start    = ctrl_wr && idle
                    && io_data[CTRL_START] && !io_data[CTRL_ABORT];
  assign abort    = ctrl_wr && !idle && io_data[CTRL_ABORT];
  // Any CPU cycle seen at the closing edge voids the engine access.
  assign commit   = !cpu_req;
  assign step     = commit && !abort && (state_q == ST_WR);
  assign src_base = ADR_W'({src_hi_q, 8'h00});
  assign dst_base = ADR_W'({dst_hi_q, 8'h00});

  cpld_dma_addrgen #(.ADR_W(ADR_W)) u_addrgen (
    .clk    (clk),
    .reset  (reset),
    .load_i (start),
    .step_i (step),
    .src_i  (src_base),
    .dst_i  (dst_base),
    .cnt_i  (page_bytes(pages_q)),
    .src_o  (src_a),
    .dst_o  (dst_a),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      src_hi_q    <= '0;
      dst_hi_q    <= '0;
      pages_q     <= '0;
      fill_q      <= '0;
      latch_q     <= '0;
      fill_mode_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (io_wr && idle) begin
        unique case (io_adr)
          REG_SRC_LO: src_hi_q[7:0]  <= io_data;
          REG_SRC_HI: src_hi_q[11:8] <= io_data[3:0];
          REG_DST_LO: dst_hi_q[7:0]  <= io_data;
          REG_DST_HI: dst_hi_q[11:8] <= io_data[3:0];
          REG_PAGES:  pages_q        <= io_data;
          REG_CTRL:   fill_mode_q    <= io_data[CTRL_FILL];
          REG_FILL:   fill_q         <= io_data;
          default: ;
        endcase
      end
      if (abort) begin
        state_q   <= ST_IDLE;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: if (start) begin
            state_q   <= io_data[CTRL_FILL] ? ST_WR : ST_RD;
            aborted_q <= 1'b0;
          end
          ST_RD: if (commit) begin
            latch_q <= ram.ram_din;
            state_q <= ST_WR;
          end
          ST_WR: if (commit) begin
            if (last) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= fill_mode_q ? ST_WR : ST_RD;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // CPU cycles pass straight through; reset parks the bus.
  always_comb begin
    ram.ramadr   = dst_a[ADR_W-2:0];
    ram.ramcs0_b = 1'b1;
    ram.ramcs1_b = 1'b1;
    ram.ramoe_b  = 1'b1;
    ram.ramwe_b  = 1'b1;
    ram.ram_dout = fill_mode_q ? fill_q : latch_q;
    ram.ram_doe  = 1'b0;
    if (!reset) begin
      if (cpu_req) begin
        ram.ramadr   = cpu_adr[ADR_W-2:0];
        ram.ramcs0_b = cpu_adr[ADR_W-1];
        ram.ramcs1_b = !cpu_adr[ADR_W-1];
        ram.ramoe_b  = cpu_rd_b;
        ram.ramwe_b  = cpu_wr_b;
      end else begin
        unique case (state_q)
          ST_RD: begin
            ram.ramadr   = src_a[ADR_W-2:0];
            ram.ramcs0_b = src_a[ADR_W-1];
            ram.ramcs1_b = !src_a[ADR_W-1];
            ram.ramoe_b  = 1'b0;
          end
          ST_WR: begin
            ram.ramcs0_b = dst_a[ADR_W-1];
            ram.ramcs1_b = !dst_a[ADR_W-1];
            ram.ramwe_b  = 1'b0;
            ram.ram_doe  = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy    = !idle;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_cpld_ram_dma.sv
// Self-checking bench for cpld_ram_dma: SRAM model plus an
// access-list reference model compared against the pins every cycle.
module tb_cpld_ram_dma;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_wr = 1'b0;
  logic [2:0]    io_adr = '0;
  logic [7:0]    io_data = '0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic          cpu_rd_b = 1'b1;
  logic          cpu_wr_b = 1'b1;
  logic          busy, done, aborted;

  cpld_ram_dma_if #(.ADR_W(AW)) bus();

  cpld_ram_dma #(.ADR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .io_wr(io_wr), .io_adr(io_adr), .io_data(io_data),
    .cpu_req(cpu_req), .cpu_adr(cpu_adr),
    .cpu_rd_b(cpu_rd_b), .cpu_wr_b(cpu_wr_b),
    .ram(bus),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  assign bus.ram_din = mem[{bus.ramcs0_b, bus.ramadr}];

  typedef struct {
    bit         wr;
    logic [19:0] adr;
    bit         use_fill;
    logic [7:0] fill;
  } acc_t;

  acc_t        q[$];
  logic [19:0] m_src = '0, m_dst = '0;
  logic [7:0]  m_pages = '0, m_fill = '0, last_rd = '0;
  bit          m_aborted = 0, exp_done = 0;

  int checks = 0, errors = 0;
  int n_done = 0, n_wr0 = 0, n_wr1 = 0;
  int cur_run = 0, last_run = 0;
  int hold = 0;
  bit rand_cpu = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic build(input bit mode);
    int n;
    n = (m_pages == 8'd0 ? 256 : int'(m_pages)) * 256;
    for (int i = 0; i < n; i++) begin
      if (!mode) q.push_back('{1'b0, m_src + 20'(i), 1'b0, 8'h00});
      q.push_back('{1'b1, m_dst + 20'(i), mode, m_fill});
    end
  endtask

  task automatic step_model();
    logic [4:0]  e_ctl, a_ctl;
    logic [19:0] e_adr, a_adr;
    logic [7:0]  e_dat;
    bit          do_adr, do_dat, busy_now, ctl;
    acc_t        h;
    a_ctl = {bus.ramcs0_b, bus.ramcs1_b, bus.ramoe_b, bus.ramwe_b,
             bus.ram_doe};
    a_adr = {bus.ramcs0_b, bus.ramadr};
    if (!reset) begin
      do_adr = 0; do_dat = 0; e_adr = '0; e_dat = '0;
      if (cpu_req) begin
        e_ctl = {cpu_adr[19], !cpu_adr[19], cpu_rd_b, cpu_wr_b, 1'b0};
        e_adr = cpu_adr; do_adr = 1;
      end else if (q.size() != 0) begin
        h = q[0];
        e_adr = h.adr; do_adr = 1;
        if (h.wr) begin
          e_ctl = {h.adr[19], !h.adr[19], 3'b101};
          e_dat = h.use_fill ? h.fill : last_rd; do_dat = 1;
        end else begin
          e_ctl = {h.adr[19], !h.adr[19], 3'b010};
        end
      end else begin
        e_ctl = 5'b11110;
      end
      chk("bus_ctl", 32'(a_ctl), 32'(e_ctl));
      if (do_adr) chk("bus_adr", 32'(a_adr), 32'(e_adr));
      if (do_dat) chk("bus_dout", 32'(bus.ram_dout), 32'(e_dat));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("done", 32'(done), 32'(exp_done));
      chk("aborted", 32'(aborted), 32'(m_aborted));
      if (done) n_done++;
      if (!bus.ramwe_b && bus.ram_doe && !cpu_req) begin
        if (bus.ramcs0_b) n_wr1++; else n_wr0++;
      end
      if (busy) cur_run++;
      else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end
    end
    if (!bus.ramwe_b && bus.ram_doe) mem[a_adr] = bus.ram_dout;
    exp_done = 0;
    if (reset) begin
      q.delete(); m_src = '0; m_dst = '0; m_pages = '0; m_fill = '0;
      m_aborted = 0; cur_run = 0;
    end else begin
      busy_now = (q.size() != 0);
      ctl = io_wr && io_adr == 3'd5;
      if (ctl && io_data[2]) begin
        if (busy_now) begin q.delete(); m_aborted = 1; end
      end else begin
        if (busy_now && !cpu_req) begin
          h = q.pop_front();
          if (!h.wr) last_rd = mem[h.adr];
          if (q.size() == 0) exp_done = 1;
        end
        if (ctl && io_data[0] && !busy_now) begin
          build(io_data[1]); m_aborted = 0;
        end
      end
      if (io_wr && !busy_now) begin
        case (io_adr)
          3'd0: m_src[15:8]  = io_data;
          3'd1: m_src[19:16] = io_data[3:0];
          3'd2: m_dst[15:8]  = io_data;
          3'd3: m_dst[19:16] = io_data[3:0];
          3'd4: m_pages      = io_data;
          3'd6: m_fill       = io_data;
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
    io_wr = 1'b0;
    if (rand_cpu) begin
      cpu_req  = ($urandom_range(4) == 0);
      cpu_adr  = AW'($urandom);
      cpu_rd_b = 1'($urandom);
      cpu_wr_b = 1'($urandom);
    end else if (hold > 0) begin
      cpu_req = 1'b1; hold--;
    end else begin
      cpu_req = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    io_wr = 1'b1; io_adr = a; io_data = d;
    tick();
  endtask

  task automatic set_xfer(input logic [19:0] s, input logic [19:0] d,
                          input logic [7:0] p);
    wr(3'd0, s[15:8]); wr(3'd1, {4'h0, s[19:16]});
    wr(3'd2, d[15:8]); wr(3'd3, {4'h0, d[19:16]});
    wr(3'd4, p);
  endtask

  task automatic clr();
    n_done = 0; n_wr0 = 0; n_wr1 = 0;
  endtask

  task automatic finish_xfer(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    chk("xfer_timeout", 32'(busy), 32'(0));
    tick();
  endtask

  function automatic int diff(input logic [19:0] a, input logic [19:0] b,
                              input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (mem[a + 20'(i)] !== mem[b + 20'(i)]) c++;
    return c;
  endfunction

  task automatic check_zero_regs();
    clr();
    wr(3'd4, 8'd1);
    wr(3'd5, 8'h03);
    chk("zr_adr", 32'({bus.ramcs0_b, bus.ramadr}), 32'(0));
    chk("zr_doe", 32'(bus.ram_doe), 32'(1));
    chk("zr_dout", 32'(bus.ram_dout), 32'(0));
    finish_xfer(600);
    chk("zr_wr0", 32'(n_wr0), 32'(256));
    chk("zr_done", 32'(n_done), 32'(1));
  endtask

  initial begin
    logic [7:0]  v10k;
    logic [19:0] s, d;
    int          bad;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_abort", 32'(aborted), 32'(0));
    chk("rst_ctl", 32'({bus.ramcs0_b, bus.ramcs1_b, bus.ramoe_b,
                        bus.ramwe_b, bus.ram_doe}), 32'(5'b11110));
    check_zero_regs();

    set_xfer(20'h12300, 20'h45600, 8'd1);
    clr();
    wr(3'd5, 8'h01);
    finish_xfer(700);
    chk("cp_run", 32'(last_run), 32'(512));
    chk("cp_done", 32'(n_done), 32'(1));
    chk("cp_wr", 32'(n_wr0), 32'(256));
    chk("cp_data", 32'(diff(20'h45600, 20'h12300, 256)), 32'(0));

    clr();
    wr(3'd5, 8'h01);
    for (int i = 0; i < 100 && !(n_wr0 >= 5 && q.size() != 0 && q[0].wr);
         i++) tick();
    cpu_adr = 20'h9ABCD; cpu_rd_b = 1'b0; cpu_wr_b = 1'b1;
    cpu_req = 1'b1; hold = 2;
    #1;
    chk("cpu_adr", 32'(bus.ramadr), 32'(19'h1ABCD));
    chk("cpu_ctl", 32'({bus.ramcs0_b, bus.ramcs1_b, bus.ramoe_b,
                        bus.ramwe_b, bus.ram_doe}), 32'(5'b10010));
    finish_xfer(700);
    cpu_rd_b = 1'b1;
    chk("stall_run", 32'(last_run), 32'(515));
    chk("stall_wr", 32'(n_wr0), 32'(256));
    chk("stall_done", 32'(n_done), 32'(1));
    chk("stall_data", 32'(diff(20'h45600, 20'h12300, 256)), 32'(0));

    set_xfer(20'h30000, 20'hFFF00, 8'd2);
    clr();
    wr(3'd5, 8'h01);
    finish_xfer(1200);
    chk("wrap_cs1", 32'(n_wr1), 32'(256));
    chk("wrap_cs0", 32'(n_wr0), 32'(256));
    chk("wrap_hi", 32'(diff(20'hFFF00, 20'h30000, 256)), 32'(0));
    chk("wrap_lo", 32'(diff(20'h00000, 20'h30100, 256)), 32'(0));

    set_xfer(20'h12300, 20'h60000, 8'd4);
    clr();
    wr(3'd5, 8'h01);
    for (int i = 0; i < 200 && (n_wr0 + n_wr1) < 10; i++) tick();
    chk("ab_cnt", 32'(n_wr0 + n_wr1), 32'(10));
    wr(3'd0, 8'h77);
    wr(3'd5, 8'h04);
    chk("ab_busy", 32'(busy), 32'(0));
    chk("ab_flag", 32'(aborted), 32'(1));
    tick(); tick();
    chk("ab_nodone", 32'(n_done), 32'(0));
    wr(3'd5, 8'h05);
    chk("sa_busy", 32'(busy), 32'(0));
    chk("sa_flag", 32'(aborted), 32'(1));
    wr(3'd4, 8'd1);
    clr();
    wr(3'd5, 8'h01);
    chk("rs_flag", 32'(aborted), 32'(0));
    chk("rs_src", 32'({bus.ramcs0_b, bus.ramadr}), 32'(20'h12300));
    chk("rs_oe", 32'(bus.ramoe_b), 32'(0));
    for (int i = 0; i < 30; i++) tick();
    wr(3'd5, 8'h01);
    finish_xfer(700);
    chk("rs_run", 32'(last_run), 32'(512));
    chk("rs_done", 32'(n_done), 32'(1));

    rand_cpu = 1;
    for (int t = 0; t < 3; t++) begin
      s = 20'($urandom) & 20'hFFF00;
      d = 20'($urandom) & 20'hFFF00;
      set_xfer(s, d, 8'($urandom_range(1, 2)));
      wr(3'd6, 8'($urandom));
      clr();
      wr(3'd5, {6'b0, 1'($urandom), 1'b1});
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(3) == 0) begin
          case ($urandom_range(7))
            0: wr(3'd0, 8'($urandom));
            1: wr(3'd1, 8'($urandom));
            2: wr(3'd2, 8'($urandom));
            3: wr(3'd3, 8'($urandom));
            4: wr(3'd4, 8'($urandom));
            5: wr(3'd5, 8'h01);
            6: wr(3'd6, 8'($urandom));
            default: wr(3'd7, 8'($urandom));
          endcase
        end else tick();
      end
      finish_xfer(5000);
      chk("rnd_done", 32'(n_done), 32'(1));
    end
    rand_cpu = 0;
    tick();

    set_xfer(20'h12300, 20'h45600, 8'd1);
    wr(3'd5, 8'h01);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1; hold = 1;
    tick();
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_done", 32'(done), 32'(0));
    chk("mr_abort", 32'(aborted), 32'(0));
    chk("mr_ctl", 32'({bus.ramcs0_b, bus.ramcs1_b, bus.ramoe_b,
                       bus.ramwe_b, bus.ram_doe}), 32'(5'b11110));
    reset = 1'b0;
    tick();
    check_zero_regs();

    v10k = mem[20'h10000];
    wr(3'd6, 8'hE5);
    set_xfer(20'h00000, 20'h00000, 8'd0);
    clr();
    wr(3'd5, 8'h03);
    finish_xfer(66000);
    chk("fill_wr", 32'(n_wr0), 32'(65536));
    chk("fill_run", 32'(last_run), 32'(65536));
    chk("fill_done", 32'(n_done), 32'(1));
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== 8'hE5) bad++;
    chk("fill_data", 32'(bad), 32'(0));
    chk("fill_edge", 32'(mem[20'h10000]), 32'(v10k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpld_ram_dma.md
CPLD_RAM_DMA -- requirements
Module: cpld_ram_dma

Interface
REQ-001 Clocking and reset SHALL be: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-002 Parameter: ADR_W, 20, expansion SRAM byte-address width (1MB, two 512KB chips).
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 io_wr  in  1  one-cycle register write strobe from the IO decoder.
REQ-006 io_adr  in  3  register offset.
REQ-007 io_data  in  8  register write data.
REQ-008 cpu_req  in  1  CPU expansion-RAM cycle in progress (card selected, mreq active, not refresh).
REQ-009 cpu_adr  in  ADR_W  CPU-side SRAM address from the bank decoder.
REQ-010 cpu_rd_b / cpu_wr_b  in  1 each  CPU-side active-low read/write enables.
REQ-011 ram_din  in  8  SRAM read data.
REQ-012 ramadr  out  ADR_W-1  SRAM address bits [18:0].
REQ-013 ramcs0_b / ramcs1_b  out  1 each  chip selects; bit 19 low selects ramcs0_b.
REQ-014 ramoe_b / ramwe_b  out  1 each  active-low SRAM output/write enables.
REQ-015 ram_dout  out  8  engine write data; ram_doe  out  1  engine drives SRAM data bus.
REQ-016 busy  out  1  engine active; done  out  1  one-cycle completion pulse; aborted  out  1  sticky abort flag.

Function
REQ-017 Registers SHALL be: 0 src[15:8], 1 src[19:16] (data[3:0]), 2 dst[15:8], 3 dst[19:16], 4 page count (0 = 256 pages), 5 control (bit0 start, bit1 fill mode, bit2 abort), 6 fill value; src/dst low byte always 0x00.
REQ-018 Writes to offsets 0-4 and 6 SHALL be ignored while busy; offset 7 and unused bits SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, RD, WR; start in IDLE -> RD (copy) or WR (fill) on the next edge, busy high from that edge.
REQ-020 RD SHALL drive src address with ramoe_b low; at the end of a committed RD cycle ram_din is latched and the FSM goes to WR.
REQ-021 WR SHALL drive dst address, ram_dout (latched byte or fill value), ram_doe high, ramwe_b low; a committed WR increments src, dst (mod 2^ADR_W) and decrements the 17-bit byte counter.
REQ-022 After the committed WR of the last byte the FSM SHALL return to IDLE, pulse done for one cycle and drop busy on the same edge.
REQ-023 CPU priority: whenever cpu_req is high, SRAM outputs SHALL be driven combinationally from the cpu_* inputs, ram_doe low, and the engine cycle is not committed (state, counters, latch unchanged; access retried).
REQ-024 An engine cycle SHALL commit only if cpu_req is low throughout the cycle as sampled at its closing edge.
REQ-025 Idle with cpu_req low SHALL give all chip selects, ramoe_b, ramwe_b high and ram_doe low.
REQ-026 Abort while busy SHALL force IDLE on the next edge, set aborted, no done pulse; start clears aborted; abort in IDLE is a no-op.
REQ-027 Start and abort written together SHALL act as abort; start while busy SHALL be ignored.
REQ-028 Address increment SHALL wrap 0xFFFFF -> 0x00000, crossing chip boundary 0x7FFFF -> 0x80000 transparently.

Reset
REQ-029 reset SHALL force IDLE, all registers 0, busy/done/aborted 0, ramcs0_b/ramcs1_b/ramoe_b/ramwe_b 1, ram_doe 0, overriding any in-flight transfer and cpu_req.

Structure
REQ-030 A shared package SHALL hold the register offset constants, control bit positions and the FSM state enum.
REQ-031 One sub-module cpld_dma_addrgen SHALL hold src/dst address and byte counters with increment/terminal-count logic.

Verification
REQ-032 Copy 1 page src 0x12300 -> dst 0x45600, cpu_req low -> 256 RD/WR pairs, 512 cycles busy, done pulse once, dst bytes equal src.
REQ-033 Fill value 0xE5, count 0, dst 0x00000 -> 65536 writes of 0xE5, done after 65536 committed WR cycles.
REQ-034 cpu_req high for 3 cycles mid-WR -> CPU address/enables on ramadr, no engine write, same byte rewritten after, total count unchanged.
REQ-035 Copy 2 pages dst 0xFFF00 -> writes at 0xFFF00-0xFFFFF on ramcs1_b then 0x00000-0x000FF on ramcs0_b.
REQ-036 Abort after 10 bytes -> busy low next edge, aborted=1, no done; writes to offset 0 during busy leave src unchanged.
REQ-037 reset asserted mid-transfer -> all outputs to reset values on next edge, registers read back as 0.
